// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply(/divide) unit.
// Optional feature macro: MDU_DIV_EN (adds DIV/DIVU funct codes).
package mdu_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W_DEF = 6;
  localparam int unsigned FUNCT_W   = 6;

  localparam logic [FUNCT_W-1:0] FN_MTHI  = 6'h11;
  localparam logic [FUNCT_W-1:0] FN_MTLO  = 6'h13;
  localparam logic [FUNCT_W-1:0] FN_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FN_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FN_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_core.sv
// Accumulator/shift datapath: one shift-add multiply step or one restoring
// divide step (MDU_DIV_EN) per asserted step. acc_next_c is the value the
// accumulator takes on the next step, so the owner can capture a final result
// in the same edge as the last step.
module mdu_core
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
`ifdef MDU_DIV_EN
  input  logic               div_mode,
`endif
  input  logic [WIDTH-1:0]   m_in,
  input  logic [WIDTH-1:0]   l_in,
  output logic [2*WIDTH-1:0] acc_next_c
);

  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;
  logic [WIDTH:0]   sum_c;
`ifdef MDU_DIV_EN
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH+1:0] diff_c;
`endif

  // Next accumulator value for a single iteration
  always_comb begin
    sum_c      = {1'b0, upper} + ({1'b0, m} & {(WIDTH+1){lower[0]}});
    acc_next_c = {sum_c, lower[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    shifted_c = {upper, lower[WIDTH-1]};
    diff_c    = {1'b0, shifted_c} - {2'b00, m};
    if (div_mode) begin
      if (!diff_c[WIDTH+1]) begin
        acc_next_c = {diff_c[WIDTH-1:0], lower[WIDTH-2:0], 1'b1};
      end else begin
        acc_next_c = {shifted_c[WIDTH-1:0], lower[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Operand load and per-iteration accumulator update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m     <= '0;
      upper <= '0;
      lower <= '0;
    end else if (load) begin
      m     <= m_in;
      upper <= '0;
      lower <= l_in;
    end else if (step) begin
      {upper, lower} <= acc_next_c;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// Iterative multiply unit with architectural HI/LO for the multi-cycle core.
// Optional feature macro: MDU_DIV_EN (restoring DIV/DIVU, same latency).
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               load_c, step_c, last_c, mthi_c, mtlo_c;
  logic               is_op_c, signed_c;
  logic [WIDTH-1:0]   a_mag_c, b_mag_c, m_in_c, l_in_c;
  logic [2*WIDTH-1:0] acc_next_c, prod_c;
`ifdef MDU_DIV_EN
  logic               is_div_c, div_mode, rem_neg, div0;
  logic [WIDTH-1:0]   a_raw, quot_c, rem_c;
`endif

  // Funct decode and operand magnitudes
  always_comb begin
    is_op_c  = (funct == FN_MULT) || (funct == FN_MULTU);
    signed_c = (funct == FN_MULT);
`ifdef MDU_DIV_EN
    is_div_c = (funct == FN_DIV) || (funct == FN_DIVU);
    is_op_c  = is_op_c || is_div_c;
    signed_c = signed_c || (funct == FN_DIV);
`endif
    a_mag_c = (signed_c && src_a[WIDTH-1]) ? WIDTH'(-src_a) : src_a;
    b_mag_c = (signed_c && src_b[WIDTH-1]) ? WIDTH'(-src_b) : src_b;
    m_in_c  = a_mag_c;
    l_in_c  = b_mag_c;
`ifdef MDU_DIV_EN
    // Divide keeps the divisor in the adder operand and the dividend in the shift half
    if (is_div_c) begin
      m_in_c = b_mag_c;
      l_in_c = a_mag_c;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and datapath controls
  always_comb begin
    next_state = state;
    load_c     = 1'b0;
    step_c     = 1'b0;
    last_c     = 1'b0;
    mthi_c     = 1'b0;
    mtlo_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_op_c) begin
            load_c     = 1'b1;
            next_state = CALC;
          end else begin
            mthi_c = (funct == FN_MTHI);
            mtlo_c = (funct == FN_MTLO);
          end
        end
      end
      CALC: begin
        step_c = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_c     = 1'b1;
          next_state = FIN;
        end
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  mdu_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (load_c),
    .step       (step_c),
`ifdef MDU_DIV_EN
    .div_mode   (div_mode),
`endif
    .m_in       (m_in_c),
    .l_in       (l_in_c),
    .acc_next_c (acc_next_c)
  );

  // Sign fixup of the final accumulator value
  always_comb begin
    prod_c = neg ? (2*WIDTH)'(-acc_next_c) : acc_next_c;
`ifdef MDU_DIV_EN
    quot_c = neg ? WIDTH'(-acc_next_c[WIDTH-1:0]) : acc_next_c[WIDTH-1:0];
    rem_c  = rem_neg ? WIDTH'(-acc_next_c[2*WIDTH-1:WIDTH]) : acc_next_c[2*WIDTH-1:WIDTH];
`endif
  end

  // Counter, operation flags, HI/LO and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      neg  <= 1'b0;
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef MDU_DIV_EN
      div_mode <= 1'b0;
      rem_neg  <= 1'b0;
      div0     <= 1'b0;
      a_raw    <= '0;
`endif
    end else begin
      busy <= (next_state != IDLE);
      done <= last_c;
      if (load_c) begin
        cnt <= '0;
        neg <= signed_c & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
`ifdef MDU_DIV_EN
        div_mode <= is_div_c;
        rem_neg  <= signed_c & src_a[WIDTH-1];
        div0     <= (src_b == '0);
        a_raw    <= src_a;
`endif
      end else if (step_c) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (mthi_c) hi <= src_a;
      if (mtlo_c) lo <= src_a;
      if (last_c) begin
`ifdef MDU_DIV_EN
        if (div_mode) begin
          if (div0) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem_c;
            lo <= quot_c;
          end
        end else begin
          {hi, lo} <= prod_c;
        end
`else
        {hi, lo} <= prod_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit (MDU_DIV_EN selects divide tests).
module tb_mdu_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  mdu_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .funct (funct),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller sits at a negedge; start is sampled at the next posedge (edge 0).
  // Returns at the negedge inside cycle 1.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    funct = f;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done, counting cycles from cur; bounded.
  task automatic wait_done(input int cur, output int cyc);
    cyc = cur;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    funct = '0;
    src_a = '0;
    src_b = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %h want 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu;
    int cyc;
    issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy_c1 got %h want 1", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL multu_hi_stale got %h want 0", hi); end
    wait_done(1, cyc);
    checks++; if (cyc != 33) begin errors++; $display("FAIL multu_latency got %0d want 33", cyc); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy_fin got %h want 1", busy); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %h want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_after got %h want 0", busy); end
  endtask

  task automatic test_mult;
    int cyc;
    issue(6'h18, 32'hFFFF_FFFD, 32'd7);
    wait_done(1, cyc);
    checks++; if (cyc != 33) begin errors++; $display("FAIL mult_latency got %0d want 33", cyc); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg_lo got %h want ffffffeb", lo); end
    @(negedge clk);
    issue(6'h18, 32'h8000_0000, 32'h8000_0000);
    wait_done(1, cyc);
    checks++; if (hi !== 32'h4000_0000) begin errors++; $display("FAIL mult_min_hi got %h want 40000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mult_min_lo got %h want 0", lo); end
    @(negedge clk);
  endtask

  task automatic test_mt;
    issue(6'h11, 32'h1234_5678, 32'h0);
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got %h want 12345678", hi); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_status got busy=%h done=%h want 0/0", busy, done); end
    issue(6'h13, 32'hCAFE_BABE, 32'h0);
    checks++; if (lo !== 32'hCAFE_BABE) begin errors++; $display("FAIL mtlo_lo got %h want cafebabe", lo); end
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi_kept got %h want 12345678", hi); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_status got busy=%h done=%h want 0/0", busy, done); end
  endtask

  task automatic test_start_while_busy;
    int cyc;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(6'h19, 32'd5, 32'd6);
    repeat (8) @(negedge clk);
    issue(6'h11, 32'h0000_DEAD, 32'h0);
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL busy_mthi_hi got %h want 0", hi); end
    wait_done(10, cyc);
    checks++; if (cyc != 33) begin errors++; $display("FAIL busy_latency got %0d want 33", cyc); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL busy_final_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd30) begin errors++; $display("FAIL busy_final_lo got %h want 1e", lo); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int cyc;
    issue(6'h18, 32'hFFFF_FFFD, 32'd7);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %h want 0", busy); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL abort_hilo got %h_%h want 0_0", hi, lo); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%h done=%h want 0/0", busy, done); end
    issue(6'h19, 32'd2, 32'd3);
    wait_done(1, cyc);
    checks++; if (cyc != 33) begin errors++; $display("FAIL abort_new_latency got %0d want 33", cyc); end
    checks++; if (lo !== 32'd6 || hi !== 32'h0) begin errors++; $display("FAIL abort_new_result got %h_%h want 0_6", hi, lo); end
  endtask

  // Begins at the negedge of a done cycle: next start is the cycle after done
  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    issue(6'h19, 32'd1000, 32'd1000);
    wait_done(1, cyc);
    checks++; if (cyc != 33) begin errors++; $display("FAIL b2b_a_latency got %0d want 33", cyc); end
    checks++; if (lo !== 32'd1000000) begin errors++; $display("FAIL b2b_a_lo got %h want 000f4240", lo); end
    @(negedge clk);
    issue(6'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, cyc);
    checks++; if (cyc != 33) begin errors++; $display("FAIL b2b_b_latency got %0d want 33", cyc); end
    checks++; if (hi !== 32'h0 || lo !== 32'd1) begin errors++; $display("FAIL b2b_b_result got %h_%h want 0_1", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_unknown;
    bit seen;
    issue(6'h00, 32'h1111_1111, 32'h2);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen) begin errors++; $display("FAIL unk00_busy got 1 want 0"); end
    checks++; if (hi !== 32'h0 || lo !== 32'd1) begin errors++; $display("FAIL unk00_hilo got %h_%h want 0_1", hi, lo); end
`ifndef MDU_DIV_EN
    issue(6'h1A, 32'd7, 32'd2);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen) begin errors++; $display("FAIL unk1a_busy got 1 want 0"); end
    checks++; if (hi !== 32'h0 || lo !== 32'd1) begin errors++; $display("FAIL unk1a_hilo got %h_%h want 0_1", hi, lo); end
`endif
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div;
    int cyc;
    issue(6'h1A, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, cyc);
    checks++; if (cyc != 33) begin errors++; $display("FAIL div_latency got %0d want 33", cyc); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
    @(negedge clk);
    issue(6'h1B, 32'd100, 32'd7);
    wait_done(1, cyc);
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL divu_result got %h_%h want 2_e", hi, lo); end
    @(negedge clk);
    issue(6'h1B, 32'd9, 32'd0);
    wait_done(1, cyc);
    checks++; if (cyc != 33) begin errors++; $display("FAIL div0_latency got %0d want 33", cyc); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got %h want ffffffff", lo); end
    checks++; if (hi !== 32'd9) begin errors++; $display("FAIL div0_hi got %h want 9", hi); end
    @(negedge clk);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_multu();
    test_mult();
    test_mt();
    test_start_while_busy();
    test_abort();
    test_back_to_back();
    test_unknown();
`ifdef MDU_DIV_EN
    test_div();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
